// File: rtl/mem_line_responder.sv
// Memory-side responder for cache line refills: single-beat writes, and line reads
// returned critical-beat-first after a fixed access latency.
module mem_line_responder #(
  parameter int unsigned AW    = 12,
  parameter int unsigned DW    = 128,
  parameter int unsigned BEATS = 4,
  parameter int unsigned LAT   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last
);

  localparam int unsigned OW    = $clog2(BEATS);
  localparam int unsigned BW    = AW - OW;
  localparam int unsigned LW    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // The beat offset field needs at least one bit, so a line is two or more beats.
  if (!is_pow2(BEATS) || BEATS < 2) begin : g_bad_beats
    $error("mem_line_responder: BEATS must be a power of 2 and at least 2");
  end
  if (LAT < 1 || LAT > 15) begin : g_bad_lat
    $error("mem_line_responder: LAT must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_e;

  logic [DW-1:0] mem [DEPTH];

  state_e        state_q, state_d;
  logic [BW-1:0] base_q, base_d;
  logic [OW-1:0] off_q, off_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_last_q, rsp_last_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;

  logic [AW-1:0] rd_addr_c;
  logic [DW-1:0] rd_data_c;
  logic          wr_en_c;

  // Address of the beat that would be loaded at the coming edge.
  always_comb begin
    rd_addr_c = {base_q, off_q};
    if (state_q == IDLE) begin
      rd_addr_c = req_addr;
    end else if (state_q == BURST) begin
      rd_addr_c = {base_q, off_q + OW'(1)};
    end
  end

  assign rd_data_c = mem[rd_addr_c];
  assign wr_en_c   = (state_q == IDLE) && req_valid && req_we;

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[req_addr] <= req_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    lat_d       = lat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_last_d  = rsp_last_q;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && !req_we) begin
          base_d = req_addr[AW-1:OW];
          off_d  = req_addr[OW-1:0];
          cnt_d  = '0;
          if (LAT == 1) begin
            state_d     = BURST;
            rsp_valid_d = 1'b1;
            rsp_last_d  = 1'b0;
            rsp_data_d  = rd_data_c;
          end else begin
            state_d = WAIT;
            lat_d   = LW'(LAT - 2);
          end
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d     = BURST;
          rsp_valid_d = 1'b1;
          rsp_last_d  = 1'b0;
          rsp_data_d  = rd_data_c;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      BURST: begin
        if (rsp_ready) begin
          if (cnt_q == OW'(BEATS - 1)) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
            rsp_last_d  = 1'b0;
          end else begin
            // Offset wraps within the line for critical-beat-first order.
            off_d      = off_q + OW'(1);
            cnt_d      = cnt_q + OW'(1);
            rsp_data_d = rd_data_c;
            rsp_last_d = (cnt_q + OW'(1)) == OW'(BEATS - 1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      lat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_data  = rsp_data_q;

  a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid_q && !rsp_ready) |=> ($stable(rsp_data_q) && $stable(rsp_last_q)));
  a_no_ready_with_valid: assert property (@(posedge clk) disable iff (!rst_n)
    !(req_ready && rsp_valid_q));
  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == BURST && rsp_ready && cnt_q == OW'(BEATS - 1)) |=> (state_q == IDLE));

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: one LAT=3 instance and one LAT=1 instance.
module tb_mem_line_responder;

  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 128;
  localparam int unsigned BEATS = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid [2];
  logic          req_ready [2];
  logic          req_we    [2];
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];
  logic          rsp_valid [2];
  logic          rsp_ready [2];
  logic [DW-1:0] rsp_data  [2];
  logic          rsp_last  [2];

  int checks   = 0;
  int failures = 0;

  beat_t         exp_q[$];
  logic [DW-1:0] model [int];

  always #5 clk = ~clk;

  mem_line_responder #(.AW(AW), .DW(DW), .BEATS(BEATS), .LAT(3)) u_dut_lat3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_data(rsp_data[0]), .rsp_last(rsp_last[0])
  );

  mem_line_responder #(.AW(AW), .DW(DW), .BEATS(BEATS), .LAT(1)) u_dut_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_data(rsp_data[1]), .rsp_last(rsp_last[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int key(input int sel, input logic [AW-1:0] a);
    return sel * (1 << AW) + int'(a);
  endfunction

  // Expected beats of a line read, wrapping from the requested beat.
  task automatic push_line(input int sel, input logic [AW-1:0] addr);
    logic [AW-1:0] a;
    beat_t         b;
    for (int k = 0; k < BEATS; k++) begin
      a = (addr & ~AW'(BEATS - 1)) | AW'((int'(addr) + k) % BEATS);
      b.data = model[key(sel, a)];
      b.last = (k == BEATS - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic do_write(input int sel, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    req_valid[sel] = 1'b1;
    req_we[sel]    = 1'b1;
    req_addr[sel]  = addr;
    req_wdata[sel] = data;
    checks++;
    if (req_ready[sel] !== 1'b1) begin
      failures++;
      $display("FAIL write_ready sel=%0d addr=%h got=%b exp=1", sel, addr, req_ready[sel]);
    end
    tick();
    model[key(sel, addr)] = data;
  endtask

  task automatic issue_read(input int sel, input logic [AW-1:0] addr);
    int w;
    w = 0;
    req_valid[sel] = 1'b1;
    req_we[sel]    = 1'b0;
    req_addr[sel]  = addr;
    req_wdata[sel] = '0;
    while (req_ready[sel] !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    checks++;
    if (w != 0) begin
      failures++;
      $display("FAIL read_accept_wait sel=%0d got=%0d cycles exp=0", sel, w);
    end
    tick();
    req_valid[sel] = 1'b0;
    push_line(sel, addr);
  endtask

  task automatic wait_first(input int sel, input int lat);
    int c;
    c = 0;
    checks++;
    if (req_ready[sel] !== 1'b0) begin
      failures++;
      $display("FAIL busy_ready sel=%0d got=%b exp=0", sel, req_ready[sel]);
    end
    while (rsp_valid[sel] !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    checks++;
    if (c != lat - 1) begin
      failures++;
      $display("FAIL first_beat_latency sel=%0d got=%0d exp=%0d", sel, c, lat - 1);
    end
  endtask

  // Drives rsp_ready from pat (LSB first, 1 after plen) and checks every presented beat.
  task automatic drain(input int sel, input logic [15:0] pat, input int plen,
                       input int max_hs, output int hs);
    int   cyc;
    bit   done;
    bit   last_seen;
    logic r;
    hs = 0; cyc = 0; done = 0; last_seen = 0;
    while (!done && cyc < 40) begin
      r = (cyc < plen) ? pat[cyc] : 1'b1;
      rsp_ready[sel] = r;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat_queue sel=%0d got=empty exp=pending beat", sel);
        done = 1;
      end else if (rsp_valid[sel] !== 1'b1 || rsp_data[sel] !== exp_q[0].data) begin
        failures++;
        $display("FAIL beat_data sel=%0d cyc=%0d valid=%b got=%h exp=%h",
                 sel, cyc, rsp_valid[sel], rsp_data[sel], exp_q[0].data);
      end
      if (!done && r) begin
        checks++;
        if (rsp_last[sel] !== exp_q[0].last) begin
          failures++;
          $display("FAIL beat_last sel=%0d hs=%0d got=%b exp=%b",
                   sel, hs, rsp_last[sel], exp_q[0].last);
        end
        last_seen = exp_q[0].last;
        void'(exp_q.pop_front());
        hs++;
        if (last_seen || hs == max_hs) done = 1;
      end
      tick();
      cyc++;
    end
    rsp_ready[sel] = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout sel=%0d got=%0d handshakes exp=%0d", sel, hs, max_hs);
    end else if (last_seen && (rsp_valid[sel] !== 1'b0 || rsp_last[sel] !== 1'b0 ||
                               req_ready[sel] !== 1'b1)) begin
      failures++;
      $display("FAIL line_end sel=%0d got valid=%b last=%b ready=%b exp 0 0 1",
               sel, rsp_valid[sel], rsp_last[sel], req_ready[sel]);
    end
  endtask

  task automatic check_hs(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = '0;
      req_wdata[s] = '0;   rsp_ready[s] = 1'b0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (req_ready[s] !== 1'b1 || rsp_valid[s] !== 1'b0 || rsp_last[s] !== 1'b0 ||
          rsp_data[s] !== '0) begin
        failures++;
        $display("FAIL reset_state sel=%0d got ready=%b valid=%b last=%b data=%h exp 1 0 0 0",
                 s, req_ready[s], rsp_valid[s], rsp_last[s], rsp_data[s]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (rsp_valid[0] !== 1'b0 || rsp_valid[1] !== 1'b0) begin
        failures++;
        $display("FAIL idle_no_rsp cyc=%0d got=%b%b exp=00", c, rsp_valid[0], rsp_valid[1]);
      end
    end
  endtask

  task automatic test_write_aligned_read();
    int hs;
    for (int i = 0; i < 4; i++) do_write(0, AW'(12'h100 + i), DW'(8'hA0 + i));
    req_valid[0] = 1'b0;
    issue_read(0, 12'h100);
    wait_first(0, 3);
    drain(0, 16'hFFFF, 16, BEATS, hs);
    check_hs("aligned_handshakes", hs, BEATS);
  endtask

  task automatic test_wrap();
    int hs;
    issue_read(0, 12'h102);
    wait_first(0, 3);
    drain(0, 16'hFFFF, 16, BEATS, hs);
    check_hs("wrap_handshakes", hs, BEATS);
  endtask

  task automatic test_backpressure();
    int hs;
    issue_read(0, 12'h100);
    wait_first(0, 3);
    drain(0, 16'b0000_0000_0111_0100, 7, BEATS, hs);
    check_hs("backpressure_handshakes", hs, BEATS);
  endtask

  task automatic test_reset_mid_burst();
    int hs;
    issue_read(0, 12'h100);
    wait_first(0, 3);
    drain(0, 16'hFFFF, 16, 2, hs);
    check_hs("pre_reset_handshakes", hs, 2);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (rsp_valid[0] !== 1'b0 || rsp_last[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_burst_reset got valid=%b last=%b ready=%b exp 0 0 1",
               rsp_valid[0], rsp_last[0], req_ready[0]);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    issue_read(0, 12'h100);
    wait_first(0, 3);
    drain(0, 16'hFFFF, 16, BEATS, hs);
    check_hs("post_reset_handshakes", hs, BEATS);
  endtask

  task automatic test_back_to_back();
    int hs;
    for (int i = 0; i < 4; i++) do_write(1, AW'(12'h100 + i), DW'(8'hB0 + i));
    do_write(1, 12'h103, DW'(8'hD3));
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_addr[1]  = 12'h100;
    tick();
    push_line(1, 12'h100);
    req_addr[1] = 12'h102;
    checks++;
    if (rsp_valid[1] !== 1'b1 || req_ready[1] !== 1'b0) begin
      failures++;
      $display("FAIL lat1_first_beat got valid=%b ready=%b exp 1 0", rsp_valid[1], req_ready[1]);
    end
    drain(1, 16'hFFFF, 16, BEATS, hs);
    check_hs("b2b_first_handshakes", hs, BEATS);
    push_line(1, 12'h102);
    tick();
    req_valid[1] = 1'b0;
    checks++;
    if (rsp_valid[1] !== 1'b1 || req_ready[1] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_accept got valid=%b ready=%b exp 1 0", rsp_valid[1], req_ready[1]);
    end
    drain(1, 16'b0000_0000_0000_1101, 4, BEATS, hs);
    check_hs("b2b_second_handshakes", hs, BEATS);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_aligned_read();
    test_wrap();
    test_backpressure();
    test_reset_mid_burst();
    test_back_to_back();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
